// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous-SRAM controller.
// Holds the FSM state enumeration, bus widths and RD_WAIT bounds.
// Verify states exist only when SRAM_CTRL_VERIFY_EN is defined.
package sram_ctrl_pkg;

   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 8;
   localparam int RD_WAIT_MIN = 1;
   localparam int RD_WAIT_MAX = 15;
   localparam int WAIT_W      = 4;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_STROBE,
      W_HOLD,
      R_ACCESS,
      R_CAPTURE
`ifdef SRAM_CTRL_VERIFY_EN
      ,
      V_ACCESS,
      V_CHECK
`endif
   } state_e;

   // Keeps an out-of-range RD_WAIT from producing a zero or overflowing wait count.
   function automatic int clamp_rd_wait(input int w);
      if (w < RD_WAIT_MIN) return RD_WAIT_MIN;
      if (w > RD_WAIT_MAX) return RD_WAIT_MAX;
      return w;
   endfunction

endpackage

// File: rtl/sram_ctrl_waitcnt.sv
// Read-access wait counter: counts the SRAM access window down from LOAD_VAL.
// Latency: done is asserted combinationally when the count reaches zero.
// No backpressure; reloads whenever load is high.
module sram_ctrl_waitcnt
   import sram_ctrl_pkg::*;
#(
   parameter logic [WAIT_W-1:0] LOAD_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic done
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   // Reload outside the access window, count down inside it, stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - WAIT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= LOAD_VAL;
      else     cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller; optional write read-back check (SRAM_CTRL_VERIFY_EN).
// Latency: write resp 3 cycles (4+RD_WAIT with verify), read resp RD_WAIT+1 cycles.
// req_ready only in IDLE; responses cannot be stalled.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int RD_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              err,
   output logic              sram_cs,
   output logic              sram_rd,
   output logic              sram_wr,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam int                RD_WAIT_C = clamp_rd_wait(RD_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_WAIT_C - 1);

   state_e            state_q, state_d;
   logic              cs_q, cs_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              resp_valid_q, resp_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              in_access;
   logic              wait_done;
`ifdef SRAM_CTRL_VERIFY_EN
   logic              err_q, err_d;
`endif

   // Flag the cycles in which the SRAM is being read and the wait counter runs.
   always_comb begin
      in_access = (state_q == R_ACCESS);
`ifdef SRAM_CTRL_VERIFY_EN
      if (state_q == V_ACCESS) in_access = 1'b1;
`endif
   end

   sram_ctrl_waitcnt #(
      .LOAD_VAL (WAIT_LOAD)
   ) u_waitcnt (
      .clk  (clk),
      .rst  (rst),
      .load (!in_access),
      .en   (in_access),
      .done (wait_done)
   );

   // Next state, request capture and read-data capture.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      din_d   = din_q;
      rdata_d = rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               din_d   = req_wdata;
               state_d = req_we ? W_SETUP : R_ACCESS;
            end
         end
         W_SETUP:  state_d = W_STROBE;
         W_STROBE: state_d = W_HOLD;
`ifdef SRAM_CTRL_VERIFY_EN
         W_HOLD:   state_d = V_ACCESS;
`else
         W_HOLD:   state_d = IDLE;
`endif
         R_ACCESS: begin
            if (wait_done) begin
               rdata_d = sram_dout;
               state_d = R_CAPTURE;
            end
         end
         R_CAPTURE: state_d = IDLE;
`ifdef SRAM_CTRL_VERIFY_EN
         V_ACCESS: begin
            if (wait_done) begin
               rdata_d = sram_dout;
               err_d   = (sram_dout != din_q);
               state_d = V_CHECK;
            end
         end
         V_CHECK:  state_d = IDLE;
`endif
         default:  state_d = IDLE;
      endcase
   end

   // SRAM strobes and the response pulse are decoded from the next state so they
   // come straight out of flops aligned with the state they belong to.
   always_comb begin
      cs_d         = 1'b0;
      rd_d         = 1'b1;
      wr_d         = 1'b0;
      resp_valid_d = 1'b0;
      case (state_d)
         W_SETUP:   cs_d = 1'b1;
         W_STROBE:  begin cs_d = 1'b1; wr_d = 1'b1; end
`ifdef SRAM_CTRL_VERIFY_EN
         W_HOLD:    cs_d = 1'b1;
         V_ACCESS:  begin cs_d = 1'b1; rd_d = 1'b0; end
         V_CHECK:   resp_valid_d = 1'b1;
`else
         W_HOLD:    begin cs_d = 1'b1; resp_valid_d = 1'b1; end
`endif
         R_ACCESS:  begin cs_d = 1'b1; rd_d = 1'b0; end
         R_CAPTURE: resp_valid_d = 1'b1;
         default:   ;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cs_q         <= 1'b0;
         rd_q         <= 1'b1;
         wr_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         rdata_q      <= '0;
`ifdef SRAM_CTRL_VERIFY_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cs_q         <= cs_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         resp_valid_q <= resp_valid_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         rdata_q      <= rdata_d;
`ifdef SRAM_CTRL_VERIFY_EN
         err_q        <= err_d;
`endif
      end
   end

   assign req_ready  = (state_q == IDLE) && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign sram_cs    = cs_q;
   assign sram_rd    = rd_q;
   assign sram_wr    = wr_q;
   assign sram_addr  = addr_q;
   assign sram_din   = din_q;
`ifdef SRAM_CTRL_VERIFY_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (RD_WAIT=1 and RD_WAIT=4) each with an SRAM model.
// Latencies are measured from the cycle a request is accepted.
// Expectations follow SRAM_CTRL_VERIFY_EN when it is defined.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_VERIFY_EN
   localparam int VERIFY = 1;
   localparam int W_LAT1 = 5;
   localparam int W_LAT4 = 8;
`else
   localparam int VERIFY = 0;
   localparam int W_LAT1 = 3;
   localparam int W_LAT4 = 3;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_we = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;

   logic       ready1, rv1, err1, cs1, rd1, wr1;
   logic [7:0] rdata1, addr1, din1, dout1;
   logic       ready4, rv4, err4, cs4, rd4, wr4;
   logic [7:0] rdata4, addr4, din4, dout4;

   logic [7:0] mem1 [0:255];
   logic [7:0] mem4 [0:255];
   bit         force0 = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int viol = 0;

   int         acc1_q[$], resp1_q[$], wr1_q[$], acc4_q[$], resp4_q[$], wr4_q[$];
   logic [7:0] rdata1_q[$], rdata4_q[$];
   logic       err1_q[$];
   logic       wr1_prev = 1'b0, wr4_prev = 1'b0;

   sram_ctrl #(.RD_WAIT(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready1),
      .resp_valid(rv1), .resp_rdata(rdata1), .err(err1),
      .sram_cs(cs1), .sram_rd(rd1), .sram_wr(wr1),
      .sram_addr(addr1), .sram_din(din1), .sram_dout(dout1)
   );

   sram_ctrl #(.RD_WAIT(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready4),
      .resp_valid(rv4), .resp_rdata(rdata4), .err(err4),
      .sram_cs(cs4), .sram_rd(rd4), .sram_wr(wr4),
      .sram_addr(addr4), .sram_din(din4), .sram_dout(dout4)
   );

   // SRAM models: write on rising sram_wr, data valid only while selected and read-enabled.
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 8'hEE;
         mem4[i] = 8'hEE;
      end
      mem1[8'h20] = 8'hC3;
   end
   always @(posedge wr1) mem1[addr1] <= din1;
   always @(posedge wr4) mem4[addr4] <= din4;
   assign dout1 = (cs1 && !rd1) ? (force0 ? 8'h00 : mem1[addr1]) : 8'hxx;
   assign dout4 = (cs4 && !rd4) ? mem4[addr4] : 8'hxx;

   always @(posedge clk) cyc <= cyc + 1;

   // Event logger and strobe-overlap monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (req_valid && ready1) acc1_q.push_back(cyc);
      if (req_valid && ready4) acc4_q.push_back(cyc);
      if (rv1) begin
         resp1_q.push_back(cyc);
         rdata1_q.push_back(rdata1);
         err1_q.push_back(err1);
      end
      if (rv4) begin
         resp4_q.push_back(cyc);
         rdata4_q.push_back(rdata4);
      end
      if (wr1 && !wr1_prev) wr1_q.push_back(cyc);
      if (wr4 && !wr4_prev) wr4_q.push_back(cyc);
      wr1_prev <= wr1;
      wr4_prev <= wr4;
      if ((wr1 && !rd1) || (wr4 && !rd4)) viol <= viol + 1;
   end

   task automatic clear_logs();
      acc1_q.delete(); resp1_q.delete(); wr1_q.delete(); rdata1_q.delete(); err1_q.delete();
      acc4_q.delete(); resp4_q.delete(); wr4_q.delete(); rdata4_q.delete();
   endtask

   task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready1 !== 1'b0 || ready4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got %b/%b, required 0/0", ready1, ready4);
      end
      checks++;
      if ({cs1, rd1, wr1, rv1, err1} !== 5'b01000 || addr1 !== 8'h00 || din1 !== 8'h00 || rdata1 !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: cs/rd/wr/rv/err=%b%b%b%b%b addr=%h din=%h rdata=%h, required 01000 00 00 00",
                  cs1, rd1, wr1, rv1, err1, addr1, din1, rdata1);
      end
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready1 !== 1'b1 || {cs1, rd1, wr1} !== 3'b010) begin
         failures++;
         $display("FAIL idle_outputs: ready=%b cs/rd/wr=%b%b%b, required 1 010", ready1, cs1, rd1, wr1);
      end
   endtask

   task automatic test_write();
      int a1, a4;
      clear_logs();
      issue(1'b1, 8'h10, 8'hA5);
      repeat (12) @(negedge clk);
      a1 = (acc1_q.size() > 0) ? acc1_q[0] : -100;
      a4 = (acc4_q.size() > 0) ? acc4_q[0] : -100;
      checks++;
      if (wr1_q.size() != 1 || wr1_q[0] - a1 != 2) begin
         failures++;
         $display("FAIL write_wr_pulse: rises=%0d first_at=%0d, required 1 at 2",
                  wr1_q.size(), (wr1_q.size() > 0) ? wr1_q[0] - a1 : -1);
      end
      checks++;
      if (resp1_q.size() != 1 || resp1_q[0] - a1 != W_LAT1 || err1_q[0] !== 1'b0) begin
         failures++;
         $display("FAIL write_resp1: count=%0d lat=%0d err=%b, required 1 %0d 0",
                  resp1_q.size(), (resp1_q.size() > 0) ? resp1_q[0] - a1 : -1, err1, W_LAT1);
      end
      checks++;
      if (resp4_q.size() != 1 || resp4_q[0] - a4 != W_LAT4) begin
         failures++;
         $display("FAIL write_resp4: count=%0d lat=%0d, required 1 %0d",
                  resp4_q.size(), (resp4_q.size() > 0) ? resp4_q[0] - a4 : -1, W_LAT4);
      end
      checks++;
      if (mem1[8'h10] !== 8'hA5 || mem4[8'h10] !== 8'hA5) begin
         failures++;
         $display("FAIL write_mem: got %h/%h, required a5/a5", mem1[8'h10], mem4[8'h10]);
      end
      checks++;
      if (addr1 !== 8'h10 || din1 !== 8'hA5) begin
         failures++;
         $display("FAIL write_bus_hold: addr=%h din=%h, required 10 a5", addr1, din1);
      end
      checks++;
      if (rdata1 !== (VERIFY != 0 ? 8'hA5 : 8'h00)) begin
         failures++;
         $display("FAIL write_rdata: got %h, required %h", rdata1, (VERIFY != 0) ? 8'hA5 : 8'h00);
      end
   endtask

   task automatic test_read();
      int a1, a4;
      clear_logs();
      issue(1'b0, 8'h10, 8'h00);
      repeat (12) @(negedge clk);
      a1 = (acc1_q.size() > 0) ? acc1_q[0] : -100;
      a4 = (acc4_q.size() > 0) ? acc4_q[0] : -100;
      checks++;
      if (resp1_q.size() != 1 || resp1_q[0] - a1 != 2 || rdata1_q[0] !== 8'hA5) begin
         failures++;
         $display("FAIL read_rw1: count=%0d lat=%0d data=%h, required 1 2 a5",
                  resp1_q.size(), (resp1_q.size() > 0) ? resp1_q[0] - a1 : -1, rdata1);
      end
      checks++;
      if (resp4_q.size() != 1 || resp4_q[0] - a4 != 5 || rdata4_q[0] !== 8'hA5) begin
         failures++;
         $display("FAIL read_rw4: count=%0d lat=%0d data=%h, required 1 5 a5",
                  resp4_q.size(), (resp4_q.size() > 0) ? resp4_q[0] - a4 : -1, rdata4);
      end
      checks++;
      if (wr1_q.size() != 0) begin
         failures++;
         $display("FAIL read_no_wr: rises=%0d, required 0", wr1_q.size());
      end
   endtask

   task automatic test_verify();
      int a1;
      clear_logs();
      issue(1'b1, 8'h30, 8'h5A);
      repeat (12) @(negedge clk);
      a1 = (acc1_q.size() > 0) ? acc1_q[0] : -100;
      checks++;
      if (resp1_q.size() != 1 || resp1_q[0] - a1 != W_LAT1 || err1_q[0] !== 1'b0) begin
         failures++;
         $display("FAIL verify_good: count=%0d lat=%0d err=%b, required 1 %0d 0",
                  resp1_q.size(), (resp1_q.size() > 0) ? resp1_q[0] - a1 : -1, err1, W_LAT1);
      end
      force0 = 1'b1;
      clear_logs();
      issue(1'b1, 8'h30, 8'h5A);
      repeat (12) @(negedge clk);
      force0 = 1'b0;
      a1 = (acc1_q.size() > 0) ? acc1_q[0] : -100;
      checks++;
      if (resp1_q.size() != 1 || resp1_q[0] - a1 != W_LAT1 || err1_q[0] !== VERIFY[0]) begin
         failures++;
         $display("FAIL verify_bad: count=%0d lat=%0d err=%b, required 1 %0d %0d",
                  resp1_q.size(), (resp1_q.size() > 0) ? resp1_q[0] - a1 : -1,
                  (err1_q.size() > 0) ? err1_q[0] : 1'bx, W_LAT1, VERIFY);
      end
      checks++;
      if (rdata1 !== (VERIFY != 0 ? 8'h00 : 8'hA5)) begin
         failures++;
         $display("FAIL verify_rdata: got %h, required %h", rdata1, (VERIFY != 0) ? 8'h00 : 8'hA5);
      end
   endtask

   task automatic test_back_to_back();
      logic       we_t [4];
      logic [7:0] wd_t [4];
      int         idx;
      logic       acc;
      we_t = '{1'b1, 1'b0, 1'b1, 1'b0};
      wd_t = '{8'h00, 8'h00, 8'h77, 8'h00};
      clear_logs();
      idx = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we_t[0]; req_addr = 8'hFF; req_wdata = wd_t[0];
      for (int n = 0; n < 80 && idx < 4; n++) begin
         @(negedge clk);
         acc = req_valid && ready1;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 4) begin
               req_we = we_t[idx]; req_wdata = wd_t[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (idx != 4 || acc1_q.size() != 4) begin
         failures++;
         $display("FAIL b2b_accepts: got %0d/%0d, required 4", idx, acc1_q.size());
      end else begin
         checks++;
         if (acc1_q[1] - acc1_q[0] != W_LAT1 + 1 || acc1_q[2] - acc1_q[1] != 3 || acc1_q[3] - acc1_q[2] != W_LAT1 + 1) begin
            failures++;
            $display("FAIL b2b_gaps: got %0d %0d %0d, required %0d 3 %0d",
                     acc1_q[1] - acc1_q[0], acc1_q[2] - acc1_q[1], acc1_q[3] - acc1_q[2], W_LAT1 + 1, W_LAT1 + 1);
         end
      end
      checks++;
      if (rdata1_q.size() != 4 || rdata1_q[1] !== 8'h00 || rdata1_q[3] !== 8'h77) begin
         failures++;
         $display("FAIL b2b_rdata: count=%0d r0=%h r1=%h, required 4 00 77", rdata1_q.size(),
                  (rdata1_q.size() > 1) ? rdata1_q[1] : 8'hxx, (rdata1_q.size() > 3) ? rdata1_q[3] : 8'hxx);
      end
      checks++;
      if (mem1[8'hFF] !== 8'h77 || addr1 !== 8'hFF) begin
         failures++;
         $display("FAIL b2b_addr_ff: mem=%h addr=%h, required 77 ff", mem1[8'hFF], addr1);
      end
   endtask

   task automatic test_reset_mid_write();
      do_reset(2);
      clear_logs();
      issue(1'b1, 8'h20, 8'h3C);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cs1 !== 1'b1 || wr1 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_setup: cs=%b wr=%b, required 1 0", cs1, wr1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (wr1_q.size() != 0 || resp1_q.size() != 0 || wr4_q.size() != 0 || resp4_q.size() != 0) begin
         failures++;
         $display("FAIL rst_mid_abort: wr=%0d/%0d resp=%0d/%0d, required 0", wr1_q.size(), wr4_q.size(),
                  resp1_q.size(), resp4_q.size());
      end
      checks++;
      if (mem1[8'h20] !== 8'hC3 || ready1 !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_mem: mem=%h ready=%b, required c3 1", mem1[8'h20], ready1);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_verify();
      test_back_to_back();
      test_reset_mid_write();
      checks++;
      if (viol != 0) begin
         failures++;
         $display("FAIL wr_rd_overlap: cycles=%0d, required 0", viol);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
